// File: rtl/sdhci_dat_pkg.sv
// sdhci_dat_pkg: shared state encoding, CRC-status tokens and CRC16 helpers for the SD DAT write path
package sdhci_dat_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_DATA,
        START,
        DAT,
        CRC,
        END_BIT,
        STATUS_WAIT,
        STATUS,
        STATUS_END,
        BUSY,
        DONE
    } dat_tx_state_e;

    localparam logic [2:0] CRC_TOKEN_OK    = 3'b010;
    localparam logic [2:0] CRC_TOKEN_ERR   = 3'b101;
    localparam logic [2:0] WRITE_TOKEN_ERR = 3'b110;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_write.sv
// crc16_write: serial CRC16 (x^16+x^12+x^5+1, init 0) accumulator for one DAT line, shifted out MSB first
module crc16_write
    import sdhci_dat_pkg::*;
(
    input  logic        sd_clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        en_i,
    input  logic        shift_i,
    input  logic        dat_i,
    output logic [15:0] crc16_o
);

    // Clear at frame start, accumulate data bits, then shift the remainder out MSB first
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i)        crc16_o <= '0;
        else if (start_i) crc16_o <= '0;
        else if (en_i)    crc16_o <= crc16_step(crc16_o, dat_i);
        else if (shift_i) crc16_o <= {crc16_o[14:0], 1'b0};
    end

endmodule

// File: rtl/dat_write.sv
// dat_write: SD host DAT-line block transmitter with CRC-status and busy handling (optional DAT_WRITE_BUS1_EN adds 1-bit mode)
module dat_write
    import sdhci_dat_pkg::*;
#(
    parameter int MaxBlockBitSize = 12,
    parameter int BusyTimeout     = 65535
) (
    input  logic                       sd_clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
`ifdef DAT_WRITE_BUS1_EN
    input  logic                       bus_width_4_i,
`endif
    input  logic [31:0]                data_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    input  logic [3:0]                 dat_i,
    output logic [3:0]                 dat_o,
    output logic                       dat_en_o,
    output logic                       done_o,
    output logic                       crc_status_err_o,
    output logic                       end_bit_err_o,
    output logic                       timeout_err_o,
    output logic                       underrun_err_o
);

    localparam int W = MaxBlockBitSize;
`ifdef DAT_WRITE_BUS1_EN
    localparam int CW = MaxBlockBitSize + 4;
`else
    localparam int CW = MaxBlockBitSize + 2;
`endif
    localparam int TW = $clog2(BusyTimeout + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BusyTimeout - 1);

    dat_tx_state_e state;
    logic [W-1:0]  size, words_left, nwords;
    logic [CW-1:0] cnt, last;
    logic [TW-1:0] tmo;
    logic [31:0]   sr, buf_data, word;
    logic [2:0]    token;
    logic [15:0]   crc [4];
    logic [3:0]    crc_msb;
    logic          buf_full, load, consume, wb, bus4, accept;
    logic          unused_bits;

    assign accept       = state == IDLE && start_i && block_size_i != '0;
    assign nwords       = W'(({1'b0, block_size_i} + (W+1)'(3)) >> 2);
    assign data_ready_o = !buf_full && (state == IDLE || words_left != '0);
    assign load         = data_valid_i && data_ready_o;
    assign wb           = bus4 ? cnt[2:0] == 3'd7 : cnt[4:0] == 5'd31;
    assign consume      = state == START || (state == DAT && cnt != last && wb);
    assign word         = buf_full ? buf_data : 32'h0;
    assign crc_msb      = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};
    assign dat_en_o     = state inside {START, DAT, CRC, END_BIT};
    assign dat_o        = state == START ? 4'h0 :
                          state == DAT   ? (bus4 ? sr[31:28] : {3'b111, sr[31]}) :
                          state == CRC   ? (bus4 ? crc_msb : {3'b111, crc_msb[0]}) : 4'hF;
    assign unused_bits  = ^{dat_i[3:1], crc[0][14:0], crc[1][14:0], crc[2][14:0], crc[3][14:0],
                            CRC_TOKEN_ERR, WRITE_TOKEN_ERR};

`ifdef DAT_WRITE_BUS1_EN
    assign last = bus4 ? CW'({size, 1'b0}) - CW'(1) : CW'({size, 3'b000}) - CW'(1);
    // Bus width is latched with each accepted start
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i)       bus4 <= 1'b1;
        else if (accept) bus4 <= bus_width_4_i;
    end
`else
    assign last = CW'({size, 1'b0}) - CW'(1);
    assign bus4 = 1'b1;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_crc
        crc16_write u_crc (
            .sd_clk_i (sd_clk_i),
            .rst_i    (rst_i),
            .start_i  (state == START),
            .en_i     (state == DAT && (bus4 || i == 0)),
            .shift_i  (state == CRC),
            .dat_i    (dat_o[i]),
            .crc16_o  (crc[i])
        );
    end

    // One-entry word buffer; a load in the same cycle as a consume keeps it full
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            buf_full <= load || (buf_full && !consume);
            if (load) buf_data <= data_i;
        end
    end

    // Transfer sequencer: frame out, CRC-status token in, busy wait, done pulse
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            size             <= '0;
            words_left       <= '0;
            cnt              <= '0;
            tmo              <= '0;
            sr               <= '0;
            token            <= '0;
            done_o           <= 1'b0;
            crc_status_err_o <= 1'b0;
            end_bit_err_o    <= 1'b0;
            timeout_err_o    <= 1'b0;
            underrun_err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (consume) begin
                sr             <= {word[7:0], word[15:8], word[23:16], word[31:24]};
                words_left     <= words_left - W'(1);
                underrun_err_o <= underrun_err_o || !buf_full;
            end
            case (state)
                IDLE: if (accept) begin
                    size             <= block_size_i;
                    words_left       <= nwords;
                    crc_status_err_o <= 1'b0;
                    end_bit_err_o    <= 1'b0;
                    timeout_err_o    <= 1'b0;
                    underrun_err_o   <= 1'b0;
                    state            <= WAIT_DATA;
                end
                WAIT_DATA: if (buf_full) state <= START;
                START: begin
                    cnt   <= '0;
                    state <= DAT;
                end
                DAT: if (cnt == last) begin
                    cnt   <= '0;
                    state <= CRC;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (!wb) sr <= bus4 ? sr << 4 : sr << 1;
                end
                CRC: if (cnt == CW'(15)) state <= END_BIT;
                     else cnt <= cnt + CW'(1);
                END_BIT: begin
                    tmo   <= '0;
                    state <= STATUS_WAIT;
                end
                STATUS_WAIT: if (!dat_i[0]) begin
                    cnt   <= '0;
                    state <= STATUS;
                end else if (tmo == TMO_LAST) begin
                    timeout_err_o <= 1'b1;
                    done_o        <= 1'b1;
                    state         <= DONE;
                end else tmo <= tmo + TW'(1);
                STATUS: begin
                    token <= {token[1:0], dat_i[0]};
                    if (cnt == CW'(2)) state <= STATUS_END;
                    else cnt <= cnt + CW'(1);
                end
                STATUS_END: begin
                    crc_status_err_o <= token != CRC_TOKEN_OK;
                    end_bit_err_o    <= !dat_i[0];
                    tmo              <= '0;
                    state            <= BUSY;
                end
                BUSY: if (dat_i[0]) begin
                    done_o <= 1'b1;
                    state  <= DONE;
                end else if (tmo == TMO_LAST) begin
                    timeout_err_o <= 1'b1;
                    done_o        <= 1'b1;
                    state         <= DONE;
                end else tmo <= tmo + TW'(1);
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
